// File: rtl/result_port_writer.sv
// -----------------------------------------------------------------------------
// result_port_writer
//
// Bus-side write initiator. Result words are queued in a small request FIFO and
// delivered one at a time to a word-addressed memory-mapped write interface.
// Each write holds mem_wen high with stable address/data until mem_ready
// accepts it, then mem_wen drops for at least GAP cycles so a receiver's
// wen edge detector counts every write exactly once. A write that waits
// TIMEOUT cycles without acceptance is dropped and the sticky err flag is set.
//
// Parameters
//   DEPTH    request FIFO entries (power of 2, >= 2)
//   GAP      idle cycles with mem_wen=0 after each write (>= 1)
//   TIMEOUT  max cycles waiting for mem_ready before abort (1..65535)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   in_valid   request offered
//   in_ready   FIFO has space (push when in_valid & in_ready)
//   in_addr    target word address
//   in_data    write data
//   mem_wen    write strobe to memory / D-cache
//   mem_addr   write address, stable while mem_wen=1
//   mem_wdata  write data, stable while mem_wen=1
//   mem_ready  write accepted this cycle (only looked at while mem_wen=1)
//   busy       FIFO non-empty or a write/gap in progress
//   sent_cnt   writes accepted by memory, wraps at 16'hFFFF
//   err        sticky timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module result_port_writer #(
    parameter int DEPTH   = 4,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [29:0] in_addr,
    input  logic [31:0] in_data,
    output logic        mem_wen,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic [15:0] sent_cnt,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_GAP
    } state_t;

    // ---------------------------------------------------------------- FIFO
    // One extra pointer bit distinguishes full from empty when the index
    // bits are equal.
    logic [61:0] fifo_mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [61:0] head;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // in_ready depends on full only, so a pop from a full FIFO does not
    // admit a push in the same cycle.
    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    assign head     = fifo_mem[rd_ptr[AW-1:0]];

    // NOTE: the storage array has no reset; validity is tracked solely by the
    // pointers, so resetting the payload would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {in_addr, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // ----------------------------------------------------------------- FSM
    state_t          state_q;
    state_t          state_d;
    logic [15:0]     tmo_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            accept;
    logic            abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        accept  = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // mem_wen is high throughout WRITE, so mem_ready is only
                // honoured while a write is on the bus. Accept is tested
                // first so it wins over a coincident timeout.
                if (mem_ready) begin
                    accept  = 1'b1;
                    state_d = S_GAP;
                end else if (tmo_cnt == TMO_LAST) begin
                    abort   = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
            sent_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            if (pop) begin
                mem_addr  <= head[61:32];
                mem_wdata <= head[31:0];
                mem_wen   <= 1'b1;
                tmo_cnt   <= '0;
            end
            if (state_q == S_WRITE && !accept && !abort) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (accept || abort) begin
                mem_wen <= 1'b0;
                gap_cnt <= GAP_LOAD;
            end
            if (accept) sent_cnt <= sent_cnt + 16'd1;
            if (abort)  err      <= 1'b1;
            if (state_q == S_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end

    assign busy = ~empty | (state_q != S_IDLE);

endmodule

// File: tb/tb_result_port_writer.sv
// -----------------------------------------------------------------------------
// tb_result_port_writer
//
// Directed self-checking bench for result_port_writer (DEPTH=4, GAP=1,
// TIMEOUT=8). A responder drives mem_ready a programmable number of cycles
// into each write; a monitor records accepted writes, write lengths,
// address/data stability and back-to-back strobes.
// -----------------------------------------------------------------------------
module tb_result_port_writer;

    localparam int DEPTH   = 4;
    localparam int GAP     = 1;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [29:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic        mem_wen;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic        busy;
    logic [15:0] sent_cnt;
    logic        err;

    result_port_writer #(
        .DEPTH   (DEPTH),
        .GAP     (GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .sent_cnt  (sent_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------ responder
    int ready_wait  = 0;   // mem_ready asserted on wen cycle ready_wait+1
    bit ready_stuck = 1'b0;
    bit ready_idle  = 1'b0; // drive mem_ready=1 while wen is low
    int hi_cyc      = 0;

    always @(negedge clk) begin
        if (!rst) begin
            hi_cyc    = 0;
            mem_ready = 1'b0;
        end else if (mem_wen) begin
            hi_cyc++;
            mem_ready = !ready_stuck && (hi_cyc == ready_wait + 1);
        end else begin
            hi_cyc    = 0;
            mem_ready = ready_idle;
        end
    end

    // -------------------------------------------------------------- monitor
    logic [61:0] obs_q[$];
    logic [61:0] exp_q[$];
    int          wen_edges = 0;
    int          hi_len    = 0;
    int          last_len  = 0;
    int          exp_len   = 1;
    int          bad_len   = 0;
    int          unstable  = 0;
    int          b2b       = 0;
    bit          prev_wen  = 1'b0;
    bit          prev_acc  = 1'b0;
    logic [29:0] hold_addr;
    logic [31:0] hold_data;

    always @(posedge mem_wen) wen_edges++;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_wen = 1'b0;
            prev_acc = 1'b0;
            hi_len   = 0;
        end else begin
            if (mem_wen) begin
                if (prev_wen && (mem_addr !== hold_addr || mem_wdata !== hold_data)) unstable++;
                if (prev_acc) b2b++;
                hold_addr = mem_addr;
                hold_data = mem_wdata;
                hi_len++;
            end else if (prev_wen) begin
                last_len = hi_len;
                if (hi_len != exp_len) bad_len++;
                hi_len = 0;
            end
            prev_acc = mem_wen && mem_ready;
            if (mem_wen && mem_ready) obs_q.push_back({mem_addr, mem_wdata});
            prev_wen = mem_wen;
        end
    end

    // ---------------------------------------------------------------- tasks
    // All stimulus tasks are entered and left on a falling clock edge.
    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        wen_edges = 0;
        bad_len   = 0;
        unstable  = 0;
        b2b       = 0;
        last_len  = 0;
        rst = 1'b1;
    endtask

    task automatic push(input logic [29:0] a, input logic [31:0] d, input bit expect_it);
        int n = 0;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("push_wait_expired", 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        if (expect_it) exp_q.push_back({a, d});
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check({tag, "_idle_expired"}, 1, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_word%0d", tag, i), obs_q[i], exp_q[i]);
        end
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_wen",      mem_wen,   0);
        check("rst_addr",     mem_addr,  0);
        check("rst_wdata",    mem_wdata, 0);
        check("rst_sent",     sent_cnt,  0);
        check("rst_err",      err,       0);
        check("rst_in_ready", in_ready,  1);
        check("rst_busy",     busy,      0);

        // 1: single word accepted on its first wen cycle, 2-cycle latency
        ready_wait = 0; exp_len = 1;
        push(30'd0, 32'd90, 1'b1);
        check("t1_wen_before", mem_wen, 0);
        check("t1_busy",       busy,    1);
        @(negedge clk);
        check("t1_wen_high",   mem_wen,   1);
        check("t1_addr",       mem_addr,  0);
        check("t1_wdata",      mem_wdata, 90);
        @(negedge clk);
        check("t1_wen_dropped", mem_wen, 0);
        wait_idle("t1");
        compare_writes("t1");
        check("t1_sent",    sent_cnt, 1);
        check("t1_len",     last_len, 1);
        check("t1_b2b",     b2b,      0);

        // 2: four words, mem_ready low for 3 cycles each
        do_reset();
        ready_wait = 3; exp_len = 4;
        push(30'h0000_0010, 32'hA000_0001, 1'b1);
        push(30'h0000_0011, 32'hA000_0002, 1'b1);
        push(30'h0000_0012, 32'hA000_0003, 1'b1);
        push(30'h0000_0013, 32'hA000_0004, 1'b1);
        check("t2_in_ready_not_full", in_ready, 1);
        wait_idle("t2");
        compare_writes("t2");
        check("t2_sent",     sent_cnt, 4);
        check("t2_bad_len",  bad_len,  0);
        check("t2_unstable", unstable, 0);
        check("t2_b2b",      b2b,      0);

        // 3: six back-to-back words into a 4-deep FIFO
        do_reset();
        ready_wait = 5; exp_len = 6;
        for (int i = 0; i < 5; i++) begin
            push(30'(32'h100 + i), 32'hC0DE_0000 + 32'(i), 1'b1);
        end
        check("t3_in_ready_full", in_ready, 0);
        push(30'h105, 32'hC0DE_0005, 1'b1);
        wait_idle("t3");
        compare_writes("t3");
        check("t3_sent",    sent_cnt, 6);
        check("t3_bad_len", bad_len,  0);
        check("t3_b2b",     b2b,      0);
        check("t3_in_ready_end", in_ready, 1);

        // 4: timeout with mem_ready stuck low (and high while wen is low)
        do_reset();
        ready_stuck = 1'b1; ready_idle = 1'b1; exp_len = TIMEOUT;
        push(30'h200, 32'hDEAD_BEEF, 1'b0);
        wait_idle("t4a");
        check("t4_err",      err,      1);
        check("t4_sent",     sent_cnt, 0);
        check("t4_len",      last_len, TIMEOUT);
        check("t4_nwrites",  64'(obs_q.size()), 0);
        ready_stuck = 1'b0; ready_idle = 1'b0; ready_wait = 0; exp_len = 1;
        push(30'h201, 32'h1234_5678, 1'b1);
        wait_idle("t4b");
        compare_writes("t4b");
        check("t4_sent_after", sent_cnt, 1);
        check("t4_err_sticky", err,      1);
        check("t4_len_after",  last_len, 1);

        // 5: mem_ready first asserted on the timeout cycle
        do_reset();
        ready_wait = TIMEOUT - 1; exp_len = TIMEOUT;
        push(30'h300, 32'h5555_AAAA, 1'b1);
        wait_idle("t5");
        compare_writes("t5");
        check("t5_err",  err,      0);
        check("t5_sent", sent_cnt, 1);
        check("t5_len",  last_len, TIMEOUT);

        // 6: reset during WRITE
        do_reset();
        ready_wait = 3; exp_len = 4;
        push(30'h400, 32'h0000_0400, 1'b0);
        push(30'h401, 32'h0000_0401, 1'b0);
        begin
            int n = 0;
            while (!mem_wen && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) check("t6_wen_wait_expired", 1, 0);
        end
        check("t6_wen_before_rst", mem_wen, 1);
        #2 rst = 1'b0;
        #1;
        check("t6_wen_async", mem_wen, 0);
        check("t6_busy_rst",  busy,    0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_busy",     busy,      0);
        check("t6_sent",     sent_cnt,  0);
        check("t6_err",      err,       0);
        check("t6_addr",     mem_addr,  0);
        check("t6_edges",    wen_edges, 1);
        check("t6_nwrites",  64'(obs_q.size()), 0);
        ready_wait = 0; exp_len = 1;
        push(30'h402, 32'h0000_0402, 1'b1);
        wait_idle("t6");
        compare_writes("t6");
        check("t6_edges_after", wen_edges, 2);
        check("t6_sent_after",  sent_cnt,  1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
